// File: rtl/fwd_hazard_scoreboard_if.sv
// Consumer/bypass bundle between the ID/EX latch and the forwarding/hazard
// unit. The master side presents the instruction entering EX. The slave side
// (fwd_hazard_scoreboard) returns operand selects, the stall request,
// store-data forwarding and the performance counters.
interface fwd_hazard_scoreboard_if #(
  parameter int REGW  = 5,
  parameter int NSRC  = 2,
  parameter int DEPTH = 3,
  parameter int SELW  = $clog2(DEPTH + 1)
);
  logic                   pipe_en;
  logic                   cons_valid;
  logic [NSRC*REGW-1:0]   cons_rs;
  logic                   cons_wen;
  logic [REGW-1:0]        cons_rd;
  logic [SELW-1:0]        cons_rdy_at;
  logic                   cons_store;
  logic [REGW-1:0]        cons_st_rt;
  logic                   flush;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic                   stall;
  logic                   st_fwd;
  logic [31:0]            stall_count;
  logic [31:0]            fwd_count;

  modport master (
    output pipe_en, cons_valid, cons_rs, cons_wen, cons_rd, cons_rdy_at,
           cons_store, cons_st_rt, flush,
    input  fwd_sel, stall, st_fwd, stall_count, fwd_count
  );

  modport slave (
    input  pipe_en, cons_valid, cons_rs, cons_wen, cons_rd, cons_rdy_at,
           cons_store, cons_st_rt, flush,
    output fwd_sel, stall, st_fwd, stall_count, fwd_count
  );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and load-use hazard unit for the pipelined MIPS core.
// The unit keeps a shift-register scoreboard of in-flight destinations over
// DEPTH post-EX stages. Entry 1 is MEM and entry DEPTH is the oldest stage.
// For each consumer operand it picks the youngest matching producer. It
// stalls the front end while that producer's result is not yet forwardable.
// It also flags store-data forwarding from entry 2 into a store in entry 1.
// Optional build macro: FWD_PERF_EN adds the stall and forward performance
// counters. Without it, both counter outputs are tied to zero.
module fwd_hazard_scoreboard #(
  parameter int REGW  = 5,
  parameter int NSRC  = 2,
  parameter int DEPTH = 3,
  parameter int SELW  = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  fwd_hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic            wen;
    logic [REGW-1:0] rd;
    logic [SELW-1:0] rdy_at;   // stored already normalised: 0 becomes 1
    logic            store;
    logic [REGW-1:0] st_rt;
  } entry_t;

  entry_t                ent_r [1:DEPTH];
  entry_t                ent_in_s;
  logic [NSRC*SELW-1:0]  fwd_sel_s;
  logic [NSRC-1:0]       hazard_s;
  logic [NSRC-1:0]       found_s;
  logic                  stall_s;
  logic                  st_fwd_s;
  logic                  enter_s;

  // An entry produces register r when it is live, writes, and targets r.
  // Register 0 is hardwired to zero, so it never matches.
  function automatic logic entry_match(input entry_t e, input logic [REGW-1:0] r);
    return e.valid && e.wen && (e.rd == r) && (r != {REGW{1'b0}});
  endfunction

  // Youngest-producer search per operand. The first hit decides both the
  // select and the hazard, so an older ready copy never hides a younger
  // one that is not ready.
  always_comb begin
    fwd_sel_s = {(NSRC*SELW){1'b0}};
    hazard_s  = {NSRC{1'b0}};
    found_s   = {NSRC{1'b0}};
    for (int s = 0; s < NSRC; s++) begin
      for (int k = 1; k <= DEPTH; k++) begin
        if (!found_s[s] && entry_match(ent_r[k], bus.cons_rs[s*REGW +: REGW])) begin
          found_s[s]                 = 1'b1;
          fwd_sel_s[s*SELW +: SELW]  = SELW'(k);
          hazard_s[s]                = (int'(ent_r[k].rdy_at) > k);
        end else begin
          found_s[s] = found_s[s];
        end
      end
    end
  end

  // A stall is requested only for a live, unflushed consumer.
  always_comb begin
    if (bus.cons_valid && !bus.flush) begin
      stall_s = |hazard_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  // A consumer enters entry 1 only when it is live, not flushed, and not
  // stalled. Otherwise a bubble is inserted.
  always_comb begin
    enter_s  = bus.cons_valid && !stall_s && !bus.flush;
    ent_in_s = '0;
    if (enter_s) begin
      ent_in_s.valid  = 1'b1;
      ent_in_s.wen    = bus.cons_wen;
      ent_in_s.rd     = bus.cons_rd;
      ent_in_s.rdy_at = (bus.cons_rdy_at == {SELW{1'b0}}) ? SELW'(1) : bus.cons_rdy_at;
      ent_in_s.store  = bus.cons_store;
      ent_in_s.st_rt  = bus.cons_st_rt;
    end else begin
      ent_in_s = '0;
    end
  end

  generate
    if (DEPTH >= 2) begin : g_st_fwd
      // A store in entry 1 takes its data from the result produced in entry 2.
      always_comb begin
        if (ent_r[1].valid && ent_r[1].store) begin
          st_fwd_s = entry_match(ent_r[2], ent_r[1].st_rt);
        end else begin
          st_fwd_s = 1'b0;
        end
      end
    end else begin : g_no_st_fwd
      assign st_fwd_s = 1'b0;
    end
  endgenerate

  // Scoreboard shift. The whole pipe freezes while pipe_en is low.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 1; k <= DEPTH; k++) begin
        ent_r[k] <= '0;
      end
    end else if (bus.pipe_en) begin
      ent_r[1] <= ent_in_s;
      for (int k = 2; k <= DEPTH; k++) begin
        ent_r[k] <= ent_r[k-1];
      end
    end
  end

  assign bus.fwd_sel = fwd_sel_s;
  assign bus.stall   = stall_s;
  assign bus.st_fwd  = st_fwd_s;

`ifdef FWD_PERF_EN
  logic [31:0] stall_count_r;
  logic [31:0] fwd_count_r;
  logic [31:0] fwd_n_s;

  // Number of operands that take a bypass this cycle.
  always_comb begin
    fwd_n_s = 32'd0;
    for (int s = 0; s < NSRC; s++) begin
      if (fwd_sel_s[s*SELW +: SELW] != {SELW{1'b0}}) begin
        fwd_n_s = fwd_n_s + 32'd1;
      end else begin
        fwd_n_s = fwd_n_s;
      end
    end
  end

  // Performance counters. Both counters wrap modulo 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_count_r <= 32'd0;
      fwd_count_r   <= 32'd0;
    end else begin
      if (stall_s && bus.pipe_en) begin
        stall_count_r <= stall_count_r + 32'd1;
      end
      if (bus.cons_valid && !stall_s && bus.pipe_en) begin
        fwd_count_r <= fwd_count_r + fwd_n_s;
      end
    end
  end

  assign bus.stall_count = stall_count_r;
  assign bus.fwd_count   = fwd_count_r;
`else
  assign bus.stall_count = 32'd0;
  assign bus.fwd_count   = 32'd0;
`endif

endmodule

// File: doc/fwd_hazard_scoreboard.md
# fwd_hazard_scoreboard

Parametrised forwarding and load-use hazard unit for the pipelined MIPS core. It keeps a shift-register scoreboard of in-flight destination registers across DEPTH post-EX stages. Each cycle it picks a bypass source for every operand of the instruction entering EX. It stalls the front end when the youngest producer's result is not yet available, and it flags store-data forwarding. It sits beside the ID/EX latch and drives the EX operand muxes and the hazard/stall controls.

## Interface
- REGW, 5, register index width
- NSRC, 2, source operands checked per consumer
- DEPTH, 3, tracked post-EX stages (entry 1 = MEM … entry DEPTH = oldest)
- SELW, $clog2(DEPTH+1), select width per operand
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- pipe_en  in  1  pipeline advance enable (0 = global freeze, e.g. memory wait)
- cons_valid  in  1  consumer instruction present at ID/EX
- cons_rs  in  NSRC*REGW  consumer source registers, operand s at [s*REGW +: REGW]
- cons_wen  in  1  consumer writes a register
- cons_rd  in  REGW  consumer destination
- cons_rdy_at  in  SELW  first entry index at which the consumer's result is forwardable (ALU 1, load 2)
- cons_store  in  1  consumer is a store
- cons_st_rt  in  REGW  store data register
- flush  in  1  kill consumer (insert bubble)
- fwd_sel  out  NSRC*SELW  per operand: 0 = register file, k = entry k
- stall  out  1  hold PC/IF/ID, bubble into entry 1
- st_fwd  out  1  store in entry 1 takes data from entry 2 result
- stall_count  out  32  stall cycles (perf)
- fwd_count  out  32  operand forwards (perf)

## Operation
- Entry fields: valid, wen, rd, rdy_at, store, st_rt. Entry k is ready iff k ≥ rdy_at.
- Match(s,k): entry k valid && wen && rd == rs[s] && rs[s] != 0.
- fwd_sel[s] = lowest k with Match(s,k), otherwise 0. The youngest producer always wins.
- Hazard(s): the lowest matching k is not ready. Older ready matches never mask a younger unready match.
- stall = cons_valid && !flush && any Hazard(s). The value is combinational from the current inputs and the registered entries.
- Shift, when pipe_en=1:
  - entry[k] ← entry[k-1] for k = 2..DEPTH
  - entry[1] ← consumer fields if cons_valid && !stall && !flush, otherwise bubble (valid=0)
- pipe_en=0: all entries hold and outputs keep evaluating.
- flush: consumer not entered, no stall asserted, older entries shift normally.
- st_fwd = entry1.valid && entry1.store && Match using entry1.st_rt against entry 2 (st_rt != 0).
- Entries never stall on stores. Store data resolves through st_fwd.

## Timing
- fwd_sel, stall and st_fwd are same-cycle combinational outputs. The scoreboard updates on the rising CLK edge.
- Load (rdy_at=2) followed immediately by a dependent: exactly 1 stall cycle, then fwd_sel=2.
- rdy_at=r with a dependent immediately behind: r-1 stall cycles (pipe_en=1 throughout).
- Stall with pipe_en=0: stall stays asserted and no cycle is consumed.
- Reset (asynchronous, any time including mid-stall): all entries invalid; fwd_sel=0, stall=0, st_fwd=0, counters=0 the same instant. The first edge after release shifts normally.
- rdy_at=0 is treated as 1. rdy_at > DEPTH means the producer is never forwardable, so the consumer stalls until the producer exits and the register file is used.

## Configuration
- FWD_PERF_EN defined:
  - stall_count increments on every cycle with stall && pipe_en.
  - fwd_count adds the number of operands with nonzero fwd_sel on cycles with cons_valid && !stall && pipe_en.
  - Both counters wrap modulo 2^32.
- FWD_PERF_EN undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
All scenarios use DEPTH=3, NSRC=2.
- ALU add r3 (rdy_at=1) entered; next consumer rs0=3, rs1=4 -> fwd_sel=(1,0), stall=0.
- lw r4 (rdy_at=2); next consumer rs1=4 -> stall=1 for 1 cycle, entry1 bubble; then fwd_sel[1]=2, stall=0.
- r5 written by entries 1 and 3, consumer rs0=5 -> fwd_sel[0]=1. Consumer rs0=0 with entry rd=0 wen=1 -> fwd_sel[0]=0.
- lw r7 then dependent held 3 cycles with pipe_en=0 -> stall=1 every cycle and entries unchanged. With pipe_en=1 -> released after 1 cycle.
- lw r7, then sw with st_rt=7 one slot behind (no stall) -> st_fwd=1 when the sw reaches entry 1 and the lw reaches entry 2.
- nRST pulsed low mid-stall -> stall=0, all selects 0 immediately. With FWD_PERF_EN, scenario 2 yields stall_count=1 and fwd_count=1.
